mul_seq: RTL and testbench

Iterative 16x16 multiplier sequencer for the unpipelined core's MULT path. It receives operands, then drives the existing ALU's operand and control inputs one micro-op per cycle, consuming the ALU's Out/Ofl/Z. It returns the low 16 bits of the product, an overflow flag and a zero flag after a fixed 35-cycle latency. It owns no adder; all arithmetic goes through the shared ALU, which the datapath top instantiates and wires to the alu_* ports.

---
 rtl/mul_seq_pkg.sv | 19 +
 rtl/mul_seq.sv | 189 ++++++++++++++++++
 tb/tb_mul_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the iterative multiplier sequencer.
package mul_seq_pkg;

   localparam int unsigned MUL_W    = 16;
   localparam int unsigned MUL_ITER = 16;

   localparam logic [2:0] ALU_ADD = 3'b000;

   // Sequencer states, kept as plain constants for older tool flows
   typedef logic [2:0] state_t;
   localparam state_t IDLE  = 3'd0;
   localparam state_t NEG_A = 3'd1;
   localparam state_t NEG_B = 3'd2;
   localparam state_t ACC   = 3'd3;
   localparam state_t DBL   = 3'd4;
   localparam state_t FIX   = 3'd5;
   localparam state_t DONE  = 3'd6;

endpackage

// File: rtl/mul_seq.sv
// Iterative 16x16 shift-and-add multiplier that borrows the shared ALU for
// every addition. Signed operands are multiplied as magnitudes and the sign
// is reapplied at the end.
module mul_seq
   import mul_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [MUL_W-1:0] a,
   input  logic [MUL_W-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic [MUL_W-1:0] product,
   output logic             ofl,
   output logic             zero,
   output logic [MUL_W-1:0] alu_a,
   output logic [MUL_W-1:0] alu_b,
   output logic             alu_cin,
   output logic [2:0]       alu_op,
   output logic             alu_inva,
   output logic             alu_invb,
   output logic             alu_sign,
   input  logic [MUL_W-1:0] alu_out,
   input  logic             alu_ofl,
   input  logic             alu_z
);

   state_t           state_q, state_d;
   logic [MUL_W-1:0] a_r_q, a_r_d;
   logic [MUL_W-1:0] mcand_q, mcand_d;
   logic [MUL_W-1:0] mplier_q, mplier_d;
   logic [MUL_W-1:0] acc_q, acc_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             neg_q, neg_d;
   logic             mc_hi_q, mc_hi_d;
   logic             ov_q, ov_d;
   logic [MUL_W-1:0] product_q, product_d;
   logic             ofl_q, ofl_d;
   logic             zero_q, zero_d;

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign product = product_q;
   assign ofl     = ofl_q;
   assign zero    = zero_q;

   // ALU micro-op for the current state; negation is ~x + 0 + 1
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_cin  = 1'b0;
      alu_op   = ALU_ADD;
      alu_inva = 1'b0;
      alu_invb = 1'b0;
      alu_sign = 1'b0;
      case (state_q)
         NEG_A: begin
            alu_a = a_r_q;
            if (sgn_q && a_r_q[MUL_W-1]) begin
               alu_inva = 1'b1;
               alu_cin  = 1'b1;
            end
         end
         NEG_B: begin
            alu_a = mplier_q;
            if (sgn_q && mplier_q[MUL_W-1]) begin
               alu_inva = 1'b1;
               alu_cin  = 1'b1;
            end
         end
         ACC: begin
            alu_a = acc_q;
            alu_b = mplier_q[0] ? mcand_q : '0;
         end
         DBL: begin
            alu_a = mcand_q;
            alu_b = mcand_q;
         end
         FIX: begin
            alu_a = acc_q;
            if (neg_q) begin
               alu_inva = 1'b1;
               alu_cin  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Next-state and register updates; start is only honoured in IDLE
   always_comb begin
      state_d   = state_q;
      a_r_d     = a_r_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      neg_d     = neg_q;
      mc_hi_d   = mc_hi_q;
      ov_d      = ov_q;
      product_d = product_q;
      ofl_d     = ofl_q;
      zero_d    = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_r_d    = a;
               mplier_d = b;
               sgn_d    = is_signed;
               neg_d    = is_signed & (a[MUL_W-1] ^ b[MUL_W-1]);
               acc_d    = '0;
               cnt_d    = '0;
               mc_hi_d  = 1'b0;
               ov_d     = 1'b0;
               state_d  = NEG_A;
            end
         end
         NEG_A: begin
            mcand_d = alu_out;
            state_d = NEG_B;
         end
         NEG_B: begin
            mplier_d = alu_out;
            state_d  = ACC;
         end
         ACC: begin
            acc_d = alu_out;
            // mc_hi: the shifted multiplicand already exceeds 16 bits
            if (mplier_q[0] && (alu_ofl || mc_hi_q)) ov_d = 1'b1;
            state_d = DBL;
         end
         DBL: begin
            mcand_d  = alu_out;
            if (alu_ofl) mc_hi_d = 1'b1;
            mplier_d = {1'b0, mplier_q[MUL_W-1:1]};
            cnt_d    = cnt_q + 4'd1;
            state_d  = (cnt_q != 4'(MUL_ITER - 1)) ? ACC : FIX;
         end
         FIX: begin
            product_d = alu_out;
            zero_d    = alu_z;
            // acc is the magnitude; 0x8000 is representable only when negative
            if (sgn_q) ofl_d = ov_q | (acc_q[MUL_W-1] & ~(neg_q & (acc_q == 16'h8000)));
            else       ofl_d = ov_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_r_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
         mc_hi_q   <= 1'b0;
         ov_q      <= 1'b0;
         product_q <= '0;
         ofl_q     <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_r_q     <= a_r_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sgn_q     <= sgn_d;
         neg_q     <= neg_d;
         mc_hi_q   <= mc_hi_d;
         ov_q      <= ov_d;
         product_q <= product_d;
         ofl_q     <= ofl_d;
         zero_q    <= zero_d;
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural adder standing in for
// the shared ALU.
module tb_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        is_signed;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ofl;
   logic        zero;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_cin;
   logic [2:0]  alu_op;
   logic        alu_inva;
   logic        alu_invb;
   logic        alu_sign;
   logic [15:0] alu_out;
   logic        alu_ofl;
   logic        alu_z;

   int checks = 0;
   int errors = 0;

   mul_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .busy      (busy),
      .done      (done),
      .product   (product),
      .ofl       (ofl),
      .zero      (zero),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_cin   (alu_cin),
      .alu_op    (alu_op),
      .alu_inva  (alu_inva),
      .alu_invb  (alu_invb),
      .alu_sign  (alu_sign),
      .alu_out   (alu_out),
      .alu_ofl   (alu_ofl),
      .alu_z     (alu_z)
   );

   // ALU: add with optional operand inverts; Ofl is the carry-out
   logic [16:0] alu_sum;
   assign alu_sum = {1'b0, (alu_inva ? ~alu_a : alu_a)} + {1'b0, (alu_invb ? ~alu_b : alu_b)}
                    + {16'd0, alu_cin};
   assign alu_out = alu_sum[15:0];
   assign alu_ofl = alu_sum[16];
   assign alu_z   = (alu_sum[15:0] == 16'd0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ofl, zero, product} from the full-precision product
   function automatic logic [17:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
      longint px;
      logic   o;
      if (s) begin
         px = longint'($signed(x)) * longint'($signed(y));
         o  = (px < -32768) || (px > 32767);
      end else begin
         px = longint'(x) * longint'(y);
         o  = (px > 65535);
      end
      return {o, (px[15:0] == 16'd0), px[15:0]};
   endfunction

   // Launch one operation from a negedge and follow it until idle again
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         output int lat, output int bcyc, output int dcnt);
      a = x; b = y; is_signed = s; start = 1'b1;
      lat = -1; bcyc = 0; dcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (busy) bcyc++;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = i;
         end
         if (lat >= 0 && !busy) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = 16'h1111; b = 16'h2222; is_signed = 1'b0;
      #2;
      checks += 6;
      if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (product !== 16'd0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
      if (ofl !== 1'b0)      begin errors++; $display("FAIL reset_ofl got %b want 0", ofl); end
      if (zero !== 1'b0)     begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
      if ({alu_a, alu_b, alu_cin, alu_op, alu_inva, alu_invb, alu_sign} !== 39'd0) begin
         errors++;
         $display("FAIL reset_alu got a=%h b=%h cin=%b op=%h ia=%b ib=%b s=%b want all 0",
                  alu_a, alu_b, alu_cin, alu_op, alu_inva, alu_invb, alu_sign);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_timing();
      int lat, bcyc, dcnt;
      run_op(16'd3, 16'd5, 1'b0, lat, bcyc, dcnt);
      checks += 6;
      if (lat !== 35)          begin errors++; $display("FAIL timing_latency got %0d want 35", lat); end
      if (bcyc !== 36)         begin errors++; $display("FAIL timing_busy_cycles got %0d want 36", bcyc); end
      if (dcnt !== 1)          begin errors++; $display("FAIL timing_done_count got %0d want 1", dcnt); end
      if (product !== 16'hF)   begin errors++; $display("FAIL timing_product got %h want 000f", product); end
      if (ofl !== 1'b0)        begin errors++; $display("FAIL timing_ofl got %b want 0", ofl); end
      if (zero !== 1'b0)       begin errors++; $display("FAIL timing_zero got %b want 0", zero); end
   endtask

   task automatic test_directed();
      // {a, b, signed, product, ofl, zero}
      logic [50:0] tbl [8];
      int lat, bcyc, dcnt;
      tbl[0] = {16'hFFFD, 16'h0007, 1'b1, 16'hFFEB, 1'b0, 1'b0};
      tbl[1] = {16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[2] = {16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b0};
      tbl[3] = {16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};
      tbl[4] = {16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
      tbl[5] = {16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[6] = {16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[7] = {16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         run_op(tbl[k][50:35], tbl[k][34:19], tbl[k][18], lat, bcyc, dcnt);
         checks += 2;
         if (lat !== 35) begin
            errors++; $display("FAIL directed_%0d_latency got %0d want 35", k, lat);
         end
         if ({product, ofl, zero} !== tbl[k][17:0]) begin
            errors++;
            $display("FAIL directed_%0d got p=%h o=%b z=%b want p=%h o=%b z=%b", k,
                     product, ofl, zero, tbl[k][17:2], tbl[k][1], tbl[k][0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [17:0] exp;
      int          dcnt = 0;
      exp = ref_mul(16'h1234, 16'h0056, 1'b0);
      a = 16'h1234; b = 16'h0056; is_signed = 1'b0; start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dcnt++;
            a = 16'h0002; b = 16'h0002; start = 1'b1;
         end
         if (i == 5 || i == 20) begin
            a = 16'hFFFF; b = 16'h7777; is_signed = 1'b1; start = 1'b1;
         end
      end
      start = 1'b0;
      checks += 3;
      if (dcnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
      if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_after got %b want 0", busy); end
      if ({ofl, zero, product} !== exp) begin
         errors++;
         $display("FAIL ignore_result got o=%b z=%b p=%h want o=%b z=%b p=%h",
                  ofl, zero, product, exp[17], exp[16], exp[15:0]);
      end
   endtask

   task automatic test_async_reset();
      int lat, bcyc, dcnt;
      int seen_done = 0;
      run_op(16'd3, 16'd5, 1'b0, lat, bcyc, dcnt);
      a = 16'h0300; b = 16'h0101; is_signed = 1'b0; start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      checks += 5;
      if (busy !== 1'b0)     begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL arst_done got %b want 0", done); end
      if (product !== 16'd0) begin errors++; $display("FAIL arst_product got %h want 0", product); end
      if (ofl !== 1'b0)      begin errors++; $display("FAIL arst_ofl got %b want 0", ofl); end
      if (zero !== 1'b0)     begin errors++; $display("FAIL arst_zero got %b want 0", zero); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++; $display("FAIL arst_aborted got %0d busy/done cycles want 0", seen_done);
      end
      run_op(16'd7, 16'd9, 1'b0, lat, bcyc, dcnt);
      checks += 2;
      if (lat !== 35) begin errors++; $display("FAIL arst_restart_latency got %0d want 35", lat); end
      if ({product, ofl, zero} !== {16'd63, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL arst_restart got p=%h o=%b z=%b want p=003f o=0 z=0", product, ofl, zero);
      end
   endtask

   task automatic test_random();
      logic [15:0] x, y;
      logic        s;
      logic [17:0] exp;
      int lat, bcyc, dcnt;
      for (int n = 0; n < 2000; n++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            1: x = {{8{x[7]}}, x[7:0]};
            2: begin x = {{8{x[7]}}, x[7:0]}; y = {{8{y[7]}}, y[7:0]}; end
            3: y = y & 16'h00FF;
            default: ;
         endcase
         exp = ref_mul(x, y, s);
         run_op(x, y, s, lat, bcyc, dcnt);
         checks += 2;
         if (lat !== 35) begin
            errors++; $display("FAIL rand_%0d_latency got %0d want 35", n, lat);
         end
         if ({ofl, zero, product} !== exp) begin
            errors++;
            $display("FAIL rand_%0d a=%h b=%h s=%b got o=%b z=%b p=%h want o=%b z=%b p=%h", n,
                     x, y, s, ofl, zero, product, exp[17], exp[16], exp[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_directed();
      test_ignore_start();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
